// File: rtl/lcd_pio_sequencer.sv
// HD44780 write sequencer: power-on wait, fixed init command list, then one host byte
// per request toggle with setup / EN / hold / execution timing and a status word for the host.
module lcd_pio_sequencer #(
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 4,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CW          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pio_cmd,
    output logic [31:0] pio_status,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        lcd_blon
);

    // state    | meaning
    // PWR_WAIT | power-on delay after reset
    // SETUP    | RS/data driven, EN low
    // EN_HI    | EN strobe high
    // HOLD     | EN low, RS/data held
    // EXEC     | wait for the LCD to execute the byte
    // IDLE     | init done, waiting for a host request
    typedef enum logic [2:0] {PWR_WAIT, SETUP, EN_HI, HOLD, EXEC, IDLE} state_t;

    // A count of 0 behaves as 1, so every terminal value is max(T,1)-1.
    localparam logic [CW-1:0] LIM_PWR   = CW'((T_POWERUP   > 0) ? T_POWERUP   - 1 : 0);
    localparam logic [CW-1:0] LIM_SETUP = CW'((T_SETUP     > 0) ? T_SETUP     - 1 : 0);
    localparam logic [CW-1:0] LIM_EN    = CW'((T_EN        > 0) ? T_EN        - 1 : 0);
    localparam logic [CW-1:0] LIM_HOLD  = CW'((T_HOLD      > 0) ? T_HOLD      - 1 : 0);
    localparam logic [CW-1:0] LIM_EXEC  = CW'((T_EXEC      > 0) ? T_EXEC      - 1 : 0);
    localparam logic [CW-1:0] LIM_LONG  = CW'((T_EXEC_LONG > 0) ? T_EXEC_LONG - 1 : 0);

    state_t          state_q, state_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic [7:0]      byte_q, byte_d;
    logic            rs_q, rs_d;
    logic            en_q, en_d;
    logic            host_q, host_d;
    logic [1:0]      idx_q, idx_d;
    logic            ack_q, ack_d;
    logic [7:0]      last_q, last_d;
    logic            busy_q, busy_d;
    logic            init_done_q, init_done_d;
    logic            on_q, blon_q;

    logic [CW-1:0]   lim;
    logic            tc;
    logic            exec_long;
    logic [7:0]      init_next;

    logic unused_pio;
    assign unused_pio = ^pio_cmd[31:12];

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    always_comb begin
        exec_long = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
        case (state_q)
            PWR_WAIT: lim = LIM_PWR;
            SETUP:    lim = LIM_SETUP;
            EN_HI:    lim = LIM_EN;
            HOLD:     lim = LIM_HOLD;
            EXEC:     lim = exec_long ? LIM_LONG : LIM_EXEC;
            default:  lim = '0;
        endcase
        tc        = (timer_q == lim);
        init_next = init_byte(idx_q + 2'd1);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = tc ? '0 : timer_q + 1'b1;
        byte_d      = byte_q;
        rs_d        = rs_q;
        host_d      = host_q;
        idx_d       = idx_q;
        ack_d       = ack_q;
        last_d      = last_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;

        case (state_q)
            PWR_WAIT: begin
                if (tc) begin
                    state_d = SETUP;
                    idx_d   = 2'd0;
                    byte_d  = init_byte(2'd0);
                    rs_d    = 1'b0;
                    host_d  = 1'b0;
                end
            end
            SETUP: if (tc) state_d = EN_HI;
            EN_HI: if (tc) state_d = HOLD;
            HOLD:  if (tc) state_d = EXEC;
            EXEC: begin
                if (tc) begin
                    if (host_q) begin
                        ack_d   = ~ack_q;
                        last_d  = byte_q;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        byte_d  = init_next;
                        state_d = SETUP;
                    end
                end
            end
            IDLE: begin
                timer_d = '0;
                busy_d  = 1'b0;
                if (pio_cmd[9] != ack_q) begin
                    byte_d  = pio_cmd[7:0];
                    rs_d    = pio_cmd[8];
                    host_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            default: begin
                state_d = PWR_WAIT;
                timer_d = '0;
            end
        endcase

        en_d = (state_d == EN_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PWR_WAIT;
            timer_q     <= '0;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            host_q      <= 1'b0;
            idx_q       <= 2'd0;
            ack_q       <= pio_cmd[9];
            last_q      <= 8'h00;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            on_q        <= 1'b0;
            blon_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            host_q      <= host_d;
            idx_q       <= idx_d;
            ack_q       <= ack_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            on_q        <= pio_cmd[10];
            blon_q      <= pio_cmd[11];
        end
    end

    assign lcd_data   = byte_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = en_q;
    assign lcd_on     = on_q;
    assign lcd_blon   = blon_q;
    assign pio_status = {16'h0000, last_q, 5'b00000, ack_q, init_done_q, busy_q};

endmodule

// File: tb/tb_lcd_pio_sequencer.sv
// Bench for lcd_pio_sequencer: expected LCD writes are queued as they are requested and
// matched against each observed EN pulse; handshake timing is checked inline per scenario.
module tb_lcd_pio_sequencer;

    localparam int TP = 100;
    localparam int TS = 2;
    localparam int TE = 3;
    localparam int TH = 2;
    localparam int TX = 10;
    localparam int TL = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pio_cmd = 32'h0;
    logic [31:0] pio_status;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

    lcd_pio_sequencer #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
        .T_EXEC(TX), .T_EXEC_LONG(TL), .CW(20)
    ) dut (
        .clk(clk), .rst(rst), .pio_cmd(pio_cmd), .pio_status(pio_status),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vectors = 0;
    int         errors  = 0;
    logic [8:0] exp_q[$];
    int         rise_at[$];
    int         n_pulses = 0;
    int         rise_c = 0;
    logic       en_prev = 1'b0;
    logic [8:0] mon_e;
    logic       req_tog = 1'b0;
    logic       on_b = 1'b0;
    logic       bl_b = 1'b0;

    // Pulse monitor: each EN rise must match the oldest queued write.
    always @(negedge clk) begin
        if (lcd_en === 1'b1 && en_prev === 1'b0) begin
            rise_c = cyc;
            rise_at.push_back(cyc);
            n_pulses++;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got rs=%b data=%h, none expected", lcd_rs, lcd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({lcd_rs, lcd_data} !== mon_e) begin
                    errors++;
                    $display("FAIL pulse_data: got rs=%b data=%h, expected rs=%b data=%h",
                             lcd_rs, lcd_data, mon_e[8], mon_e[7:0]);
                end
            end
            vectors++;
            if (lcd_rw !== 1'b0) begin
                errors++;
                $display("FAIL lcd_rw: got %b, expected 0", lcd_rw);
            end
        end
        if (lcd_en === 1'b0 && en_prev === 1'b1 && !rst) begin
            vectors++;
            if (cyc - rise_c != TE) begin
                errors++;
                $display("FAIL en_width: got %0d cycles, expected %0d", cyc - rise_c, TE);
            end
        end
        en_prev = lcd_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] b, input logic r);
        pio_cmd = {20'h0, bl_b, on_b, req_tog, r, b};
    endtask

    task automatic release_reset(output int rel);
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        rise_at.delete();
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(8'h00, 1'b0);
        tick(3);
        vectors++;
        if (lcd_en !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_pins: got en=%b rs=%b data=%h, expected 0 0 00", lcd_en, lcd_rs, lcd_data);
        end
        vectors++;
        if (lcd_on !== 1'b0 || lcd_blon !== 1'b0 || lcd_rw !== 1'b0) begin
            errors++;
            $display("FAIL reset_power: got on=%b blon=%b rw=%b, expected 0 0 0", lcd_on, lcd_blon, lcd_rw);
        end
        vectors++;
        if (pio_status !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_status: got %h, expected 00000001", pio_status);
        end
    endtask

    task automatic test_init;
        int rel;
        int p0;
        logic got;
        p0 = n_pulses;
        release_reset(rel);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (pio_status[1] === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!got || n_pulses - p0 != 4) begin
            errors++;
            $display("FAIL init_complete: got done=%b pulses=%0d, expected 1 and 4", got, n_pulses - p0);
        end else begin
            vectors++;
            if (rise_at[0] - rel != TP + TS) begin
                errors++;
                $display("FAIL init_first_en: got %0d cycles, expected %0d", rise_at[0] - rel, TP + TS);
            end
            vectors++;
            if (rise_at[1] - rise_at[0] != TE + TH + TX + TS) begin
                errors++;
                $display("FAIL init_gap_38: got %0d, expected %0d", rise_at[1] - rise_at[0], TE + TH + TX + TS);
            end
            vectors++;
            if (rise_at[3] - rise_at[2] != TE + TH + TL + TS) begin
                errors++;
                $display("FAIL init_gap_01: got %0d, expected %0d", rise_at[3] - rise_at[2], TE + TH + TL + TS);
            end
            vectors++;
            if (cyc - rise_at[3] != TE + TH + TX) begin
                errors++;
                $display("FAIL init_done_time: got %0d, expected %0d", cyc - rise_at[3], TE + TH + TX);
            end
        end
        vectors++;
        if (pio_status[0] !== 1'b0) begin
            errors++;
            $display("FAIL init_busy: got %b, expected 0", pio_status[0]);
        end
    endtask

    task automatic test_write(input logic [7:0] b, input logic r, input int exp_lat);
        int c0;
        logic got;
        vectors++;
        if (pio_status[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle_%h: busy got %b, expected 0", b, pio_status[0]);
        end
        req_tog = ~req_tog;
        drive(b, r);
        exp_q.push_back({r, b});
        c0 = cyc;
        @(negedge clk);
        vectors++;
        if (pio_status[0] !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy_%h: got %b, expected 1", b, pio_status[0]);
        end
        drive(~b, ~r);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (pio_status[2] === req_tog) begin got = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!got || cyc - (c0 + 1) != exp_lat) begin
            errors++;
            $display("FAIL wr_ack_lat_%h: got %0d (seen=%b), expected %0d", b, cyc - (c0 + 1), got, exp_lat);
        end
        vectors++;
        if (pio_status[15:8] !== b || pio_status[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_status_%h: got last=%h busy=%b, expected %h 0", b, pio_status[15:8], pio_status[0], b);
        end
    endtask

    task automatic test_pending_during_init;
        int rel;
        int p0;
        logic got;
        rst = 1'b1;
        drive(8'h00, 1'b0);
        tick(2);
        p0 = n_pulses;
        release_reset(rel);
        while (cyc < rel + 20) @(negedge clk);
        req_tog = ~req_tog;
        drive(8'h55, 1'b1);
        exp_q.push_back({1'b1, 8'h55});
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (pio_status[2] === req_tog) begin got = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!got || n_pulses - p0 != 5) begin
            errors++;
            $display("FAIL pend_ack: got ack_seen=%b pulses=%0d, expected 1 and 5", got, n_pulses - p0);
        end else begin
            vectors++;
            if (cyc - rise_at[4] != TE + TH + TX) begin
                errors++;
                $display("FAIL pend_ack_time: got %0d, expected %0d", cyc - rise_at[4], TE + TH + TX);
            end
        end
        tick(40);
        vectors++;
        if (n_pulses - p0 != 5 || pio_status[2] !== req_tog || pio_status[15:8] !== 8'h55) begin
            errors++;
            $display("FAIL pend_single: got pulses=%0d ack=%b last=%h, expected 5 %b 55",
                     n_pulses - p0, pio_status[2], pio_status[15:8], req_tog);
        end
    endtask

    task automatic test_reset_mid_write;
        int rel;
        int p0;
        logic got;
        logic bad_busy;
        req_tog = ~req_tog;
        drive(8'h41, 1'b1);
        exp_q.push_back({1'b1, 8'h41});
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (lcd_en === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL rstmid_en: got no EN pulse, expected one");
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (lcd_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_en_drop: got %b, expected 0", lcd_en);
        end
        vectors++;
        if (pio_status !== {16'h0, 8'h00, 5'b0, req_tog, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_status: got %h, expected %h", pio_status,
                     {16'h0, 8'h00, 5'b0, req_tog, 1'b0, 1'b1});
        end
        tick(1);
        p0 = n_pulses;
        release_reset(rel);
        got = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (pio_status[1] === 1'b1) begin got = 1'b1; break; end
            if (pio_status[0] !== 1'b1) bad_busy = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (!got || bad_busy) begin
            errors++;
            $display("FAIL rstmid_reinit: got done=%b busy_dropped=%b, expected 1 0", got, bad_busy);
        end
        tick(40);
        vectors++;
        if (n_pulses - p0 != 4 || pio_status[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_replay: got pulses=%0d busy=%b, expected 4 0", n_pulses - p0, pio_status[0]);
        end
    endtask

    task automatic test_power_bits;
        logic got;
        req_tog = ~req_tog;
        drive(8'h30, 1'b1);
        exp_q.push_back({1'b1, 8'h30});
        tick(2);
        on_b = 1'b1;
        bl_b = 1'b1;
        drive(8'h30, 1'b1);
        vectors++;
        if (lcd_on !== 1'b0 || lcd_blon !== 1'b0 || pio_status[0] !== 1'b1) begin
            errors++;
            $display("FAIL pwr_before: got on=%b blon=%b busy=%b, expected 0 0 1", lcd_on, lcd_blon, pio_status[0]);
        end
        @(negedge clk);
        vectors++;
        if (lcd_on !== 1'b1 || lcd_blon !== 1'b1 || lcd_rw !== 1'b0) begin
            errors++;
            $display("FAIL pwr_on: got on=%b blon=%b rw=%b, expected 1 1 0", lcd_on, lcd_blon, lcd_rw);
        end
        bl_b = 1'b0;
        drive(8'h30, 1'b1);
        @(negedge clk);
        vectors++;
        if (lcd_on !== 1'b1 || lcd_blon !== 1'b0) begin
            errors++;
            $display("FAIL pwr_blon_off: got on=%b blon=%b, expected 1 0", lcd_on, lcd_blon);
        end
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pio_status[2] === req_tog) begin got = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!got || pio_status[15:8] !== 8'h30) begin
            errors++;
            $display("FAIL pwr_write_ack: got ack_seen=%b last=%h, expected 1 30", got, pio_status[15:8]);
        end
    endtask

    initial begin
        test_reset;
        test_init;
        tick(2);
        test_write(8'h41, 1'b1, TS + TE + TH + TX);
        tick(1);
        test_write(8'h01, 1'b0, TS + TE + TH + TL);
        tick(1);
        test_write(8'h80, 1'b0, TS + TE + TH + TX);
        tick(1);
        test_write(8'h00, 1'b0, TS + TE + TH + TX);
        test_pending_during_init;
        tick(2);
        test_reset_mid_write;
        tick(2);
        test_power_bits;
        tick(5);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes: got %0d unserved, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
